instruction_sender: RTL and testbench
=====================================

Name: instruction_sender

Overview:
- Host-side initiator for the TitanComms SPI instruction protocol, the transmit end of the core-side instruction decoder.
- Accepts one WRITE or READ command per handshake and serializes it into the protocol byte stream for a byte-level SPI controller.
- For READ, follows the address frame with TRANSFER bytes and reassembles the 32-bit value returned MSB first.
- Sits between host logic and the SPI byte engine.

Parameters:
- ADDRESS_WIDTH, 24, command address width; must be 24 (3 bytes on the wire).
- VALUE_WIDTH, 32, command and response value width; must be 32 (4 bytes on the wire).
- TRAILER_BYTE, 8'h00, filler byte sent after the last TRANSFER to clock out its response.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  8  opcode; WRITE or READ (TitanComms).
- cmd_address  in  24  target address.
- cmd_value  in  32  write data; ignored for READ.
- rsp_valid  out  1  one-cycle pulse: command complete.
- rsp_value  out  32  read data; held until the next READ completes.
- rsp_error  out  1  one-cycle pulse: unsupported opcode, no bytes sent.
- spi_tx_valid  out  1  byte offered to the SPI controller.
- spi_tx_ready  in  1  controller accepts the byte.
- spi_tx_byte  out  8  byte to shift out.
- spi_rx_valid  in  1  one-cycle pulse: exchange finished.
- spi_rx_byte  in  8  byte shifted in during that exchange.

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE; rsp_valid=0; rsp_error=0; rsp_value=0; spi_tx_valid=0; spi_tx_byte=0; state IDLE; byte index 0.
- Reset mid-command: return to IDLE at once, drop spi_tx_valid, emit no rsp pulse, and discard partial rsp data. A later stale spi_rx_valid seen in IDLE is ignored.
- States:
  - IDLE: cmd_valid&cmd_ready latches op, address and value.
    - WRITE or READ: go to LOAD.
    - Any other opcode: pulse rsp_error next cycle and stay in IDLE.
  - LOAD: drive spi_tx_byte = frame[idx] and spi_tx_valid=1; go to SEND.
  - SEND: hold byte and valid until spi_tx_valid&spi_tx_ready, then deassert valid and go to WAIT_RX.
  - WAIT_RX: wait for spi_tx_rx_valid pulse (spi_rx_valid).
    - If idx is the last index, go to DONE.
    - Otherwise idx++ and go to LOAD.
  - DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- Only one byte is ever outstanding; a new byte is never offered before spi_rx_valid for the previous one. Minimum 3 cycles per byte.
- WRITE frame, 8 bytes: WRITE, addr[23:16], addr[15:8], addr[7:0], val[31:24], val[23:16], val[15:8], val[7:0].
- READ frame, 9 bytes: READ, addr[23:16], addr[15:8], addr[7:0], TRANSFER x4, TRAILER_BYTE.
- Read data capture:
  - The responder loads each TRANSFER's answer for the next exchange.
  - The spi_rx_byte received in the exchanges for frame indices 5..8 is shifted into an accumulator MSB first.
  - rsp_value is updated from the accumulator in the same cycle rsp_valid pulses.
  - Bytes received during all other indices are discarded.
- spi_rx_valid arriving in LOAD or SEND is a protocol violation: ignore it, no state change.
- cmd_valid asserted while busy is not accepted; cmd_ready stays 0.

Optional Feature:
- Macro: TITAN_SENDER_REPEAT_EN.
- Defined: the READ frame inserts a REPEAT byte at index 4, before the first TRANSFER, so the responder's data pointer restarts at the MSB. The frame becomes 10 bytes and capture moves to indices 6..9.
- Undefined: 9-byte READ frame as above, with no REPEAT sent.

Decomposition:
- TitanComms package: opcode enum (WRITE=1, READ=2, STREAM=3, TRANSFER=4, REPEAT=5), sender state enum, WRITE_FRAME_LEN=8, READ_FRAME_LEN (9 or 10 under the macro).
- Sub-module frame_builder: combinational mux from (op, address, value, idx) to the outgoing byte, keeping frame layout out of the FSM.

Test Plan:
- WRITE addr=24'h000010 val=32'hDEADBEEF, tx_ready always 1, rx 2 cycles after accept → tx bytes 01 00 00 10 DE AD BE EF; one rsp_valid; rsp_value unchanged.
- READ addr=24'hABCDEF; responder model answers 12,34,56,78 on the exchanges after each TRANSFER → tx 02 AB CD EF 04 04 04 04 00; rsp_value=32'h12345678.
- Same READ with TITAN_SENDER_REPEAT_EN defined → tx 02 AB CD EF 05 04 04 04 04 00; rsp_value=32'h12345678.
- cmd_op=8'h07 → no spi_tx_valid; rsp_error pulses once; cmd_ready back to 1 the following cycle.
- spi_tx_ready held low 5 cycles on byte 3 → spi_tx_byte and spi_tx_valid stable throughout; cmd_valid during WRITE is ignored (cmd_ready=0).
- rst pulsed after byte 2 of a READ → spi_tx_valid=0 next cycle, no rsp_valid; a following spi_rx_valid is ignored; a new WRITE completes normally.

Source files
------------

// File: rtl/instruction_sender_pkg.sv
// TitanComms protocol constants, opcode and sender state enums, frame geometry.
// Optional macro TITAN_SENDER_REPEAT_EN lengthens the READ frame by a REPEAT byte.
package instruction_sender_pkg;

    localparam int ADDR_W = 24;
    localparam int VAL_W  = 32;

    typedef enum logic [7:0] {
        OP_WRITE    = 8'h01,
        OP_READ     = 8'h02,
        OP_STREAM   = 8'h03,
        OP_TRANSFER = 8'h04,
        OP_REPEAT   = 8'h05
    } titan_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_DONE    = 3'd4
    } sender_state_e;

    localparam int WRITE_FRAME_LEN = 8;
`ifdef TITAN_SENDER_REPEAT_EN
    localparam int READ_FRAME_LEN  = 10;
`else
    localparam int READ_FRAME_LEN  = 9;
`endif

    localparam logic [3:0] WRITE_LAST_IDX    = 4'(WRITE_FRAME_LEN - 1);
    localparam logic [3:0] READ_LAST_IDX     = 4'(READ_FRAME_LEN - 1);
    // The four returned data bytes arrive in the last four exchanges of a READ.
    localparam logic [3:0] CAPTURE_FIRST_IDX = 4'(READ_FRAME_LEN - 4);

    function automatic logic is_supported(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/instruction_sender_if.sv
// Command, response and SPI byte-engine signals of the instruction sender.
// master = the sender itself; slave = host logic plus SPI controller.
interface instruction_sender_if;
    import instruction_sender_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_address;
    logic [VAL_W-1:0]  cmd_value;
    logic              rsp_valid;
    logic [VAL_W-1:0]  rsp_value;
    logic              rsp_error;
    logic              spi_tx_valid;
    logic              spi_tx_ready;
    logic [7:0]        spi_tx_byte;
    logic              spi_rx_valid;
    logic [7:0]        spi_rx_byte;

    modport master (
        input  cmd_valid, cmd_op, cmd_address, cmd_value,
        input  spi_tx_ready, spi_rx_valid, spi_rx_byte,
        output cmd_ready, rsp_valid, rsp_value, rsp_error,
        output spi_tx_valid, spi_tx_byte
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_address, cmd_value,
        output spi_tx_ready, spi_rx_valid, spi_rx_byte,
        input  cmd_ready, rsp_valid, rsp_value, rsp_error,
        input  spi_tx_valid, spi_tx_byte
    );

endinterface

// File: rtl/instruction_sender_frame_builder.sv
// Combinational map (op, address, value, idx) -> outgoing protocol byte; zero latency, no backpressure.
// TITAN_SENDER_REPEAT_EN inserts REPEAT at READ index 4.
module instruction_sender_frame_builder
    import instruction_sender_pkg::*;
#(
    parameter logic [7:0] TRAILER_BYTE = 8'h00
) (
    input  logic [7:0]        op_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [VAL_W-1:0]  value_i,
    input  logic [3:0]        idx_i,
    output logic [7:0]        byte_o
);

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            4'd0: byte_o = op_i;
            4'd1: byte_o = address_i[23:16];
            4'd2: byte_o = address_i[15:8];
            4'd3: byte_o = address_i[7:0];
            default: begin
                if (op_i == OP_WRITE) begin
                    case (idx_i)
                        4'd4:    byte_o = value_i[31:24];
                        4'd5:    byte_o = value_i[23:16];
                        4'd6:    byte_o = value_i[15:8];
                        4'd7:    byte_o = value_i[7:0];
                        default: byte_o = 8'h00;
                    endcase
                end else if (idx_i == READ_LAST_IDX) begin
                    byte_o = TRAILER_BYTE;
`ifdef TITAN_SENDER_REPEAT_EN
                end else if (idx_i == 4'd4) begin
                    byte_o = OP_REPEAT;
`endif
                end else if (idx_i < READ_LAST_IDX) begin
                    byte_o = OP_TRANSFER;
                end
            end
        endcase
    end

endmodule

// File: rtl/instruction_sender.sv
// TitanComms SPI instruction initiator: serialises WRITE/READ frames one byte at a time, reassembles READ data.
// Latency: 3 cycles minimum per byte plus one DONE cycle; cmd_ready only in IDLE, bytes held until spi_tx_ready.
// Optional macro TITAN_SENDER_REPEAT_EN (10-byte READ frame with REPEAT before the TRANSFERs).
module instruction_sender
    import instruction_sender_pkg::*;
#(
    parameter int         ADDRESS_WIDTH = 24,
    parameter int         VALUE_WIDTH   = 32,
    parameter logic [7:0] TRAILER_BYTE  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_sender_if.master bus
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_LOAD    = ST_LOAD;
    localparam logic [2:0] S_SEND    = ST_SEND;
    localparam logic [2:0] S_WAIT_RX = ST_WAIT_RX;
    localparam logic [2:0] S_DONE    = ST_DONE;

    logic [2:0]               state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic [7:0]               op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [VALUE_WIDTH-1:0]   val_q, val_d;
    logic [VALUE_WIDTH-1:0]   acc_q, acc_d;
    logic [VALUE_WIDTH-1:0]   rsp_value_q, rsp_value_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [7:0]               tx_byte_q, tx_byte_d;
    logic [7:0]               frame_byte;
    logic [3:0]               last_idx;

    instruction_sender_frame_builder #(
        .TRAILER_BYTE (TRAILER_BYTE)
    ) u_frame_builder (
        .op_i      (op_q),
        .address_i (addr_q),
        .value_i   (val_q),
        .idx_i     (idx_q),
        .byte_o    (frame_byte)
    );

    assign last_idx = (op_q == OP_READ) ? READ_LAST_IDX : WRITE_LAST_IDX;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        val_d       = val_q;
        acc_d       = acc_q;
        rsp_value_d = rsp_value_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        tx_valid_d  = tx_valid_q;
        tx_byte_d   = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    addr_d = bus.cmd_address;
                    val_d  = bus.cmd_value;
                    idx_d  = 4'd0;
                    acc_d  = '0;
                    if (is_supported(bus.cmd_op)) begin
                        state_d = S_LOAD;
                    end else begin
                        rsp_error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = frame_byte;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (bus.spi_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (bus.spi_rx_valid) begin
                    // Only the exchanges following each TRANSFER carry read data.
                    if (op_q == OP_READ && idx_q >= CAPTURE_FIRST_IDX) begin
                        acc_d = {acc_q[VALUE_WIDTH-9:0], bus.spi_rx_byte};
                    end
                    if (idx_q == last_idx) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        if (op_q == OP_READ) begin
                            rsp_value_d = {acc_q[VALUE_WIDTH-9:0], bus.spi_rx_byte};
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            op_q        <= 8'h00;
            addr_q      <= '0;
            val_q       <= '0;
            acc_q       <= '0;
            rsp_value_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            val_q       <= val_d;
            acc_q       <= acc_d;
            rsp_value_q <= rsp_value_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE) && !rst;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_value    = rsp_value_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.spi_tx_valid = tx_valid_q;
    assign bus.spi_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_instruction_sender.sv
// Bench for instruction_sender: directed vector table, reset/stall sequences, randomized commands
// checked against a frame-level reference and a behavioural TitanComms responder.
module tb_instruction_sender;
    import instruction_sender_pkg::*;

`ifdef TITAN_SENDER_REPEAT_EN
    localparam int RD_LEN = 10;
`else
    localparam int RD_LEN = 9;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [31:0] val;
        logic [31:0] rdata;
        int          rx_delay;
        int          ready_mode;
        bit          poke;
        int          exp_len;
        bit          exp_err;
        logic [31:0] exp_rsp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_sender_if bus();

    instruction_sender #(
        .ADDRESS_WIDTH (24),
        .VALUE_WIDTH   (32),
        .TRAILER_BYTE  (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_f[10];
    int          rx_cnt, rx_delay, ready_mode, stall_cnt, ptr;
    logic [7:0]  rx_next, pending;
    logic [31:0] rdata, rsp_seen, model_rsp;
    int          rsp_cnt, err_cnt, proto_err;
    bit          prev_stall, legit_rx, poke, inject_rx;
    logic [7:0]  prev_byte;
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected wire frame, straight from the protocol's frame layout.
    function automatic int build_frame(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        int k;
        for (int i = 0; i < 10; i++) exp_f[i] = 8'h00;
        if (op != 8'h01 && op != 8'h02) return 0;
        exp_f[0] = op;
        exp_f[1] = a[23:16];
        exp_f[2] = a[15:8];
        exp_f[3] = a[7:0];
        if (op == 8'h01) begin
            exp_f[4] = v[31:24]; exp_f[5] = v[23:16]; exp_f[6] = v[15:8]; exp_f[7] = v[7:0];
            return 8;
        end
        k = 4;
`ifdef TITAN_SENDER_REPEAT_EN
        exp_f[4] = 8'h05;
        k = 5;
`endif
        for (int i = 0; i < 4; i++) begin
            exp_f[k] = 8'h04;
            k++;
        end
        exp_f[k] = 8'h00;
        return k + 1;
    endfunction

    // One clock: observe the settled cycle, take the edge, then drive the responder for the next cycle.
    task automatic tick();
        logic [7:0] b;
        int pos;
        #1;
        if (bus.spi_tx_valid && (rx_cnt > 0 || legit_rx)) proto_err++;
        if (prev_stall && (!bus.spi_tx_valid || bus.spi_tx_byte !== prev_byte)) proto_err++;
        prev_stall = bus.spi_tx_valid && !bus.spi_tx_ready;
        prev_byte  = bus.spi_tx_byte;
        if (bus.spi_tx_valid && bus.spi_tx_ready) begin
            b = bus.spi_tx_byte;
            tx_q.push_back(b);
            pos = tx_q.size() - 1;
            rx_next = pending;
            rx_cnt  = rx_delay;
            if (tx_q[0] == 8'h02 && pos >= 4 && b == 8'h04 && ptr < 4) begin
                pending = 8'(rdata >> (8 * (3 - ptr)));
                ptr++;
            end else begin
                if (tx_q[0] == 8'h02 && pos >= 4 && b == 8'h05) ptr = 0;
                pending = 8'($urandom);
            end
        end
        if (poke && bus.cmd_ready) proto_err++;
        if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_seen = bus.rsp_value;
            if (poke) begin
                poke = 1'b0;
                bus.cmd_valid = 1'b0;
            end
        end
        if (bus.rsp_error) err_cnt++;
        @(posedge clk);
        #1;
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_byte  = 8'($urandom);
        legit_rx = 1'b0;
        if (inject_rx) begin
            bus.spi_rx_valid = 1'b1;
            inject_rx = 1'b0;
        end else if (rx_cnt > 0) begin
            rx_cnt--;
            if (rx_cnt == 0) begin
                bus.spi_rx_valid = 1'b1;
                bus.spi_rx_byte  = rx_next;
                legit_rx = 1'b1;
            end
        end
        case (ready_mode)
            0: bus.spi_tx_ready = 1'b1;
            1: bus.spi_tx_ready = 1'($urandom_range(0, 1));
            2: begin
                if (tx_q.size() == 3 && stall_cnt < 5) begin
                    bus.spi_tx_ready = 1'b0;
                    if (bus.spi_tx_valid) begin
                        stall_cnt++;
                        // Stray exchange-done while the byte is still unaccepted must be ignored.
                        if (stall_cnt == 3) bus.spi_rx_valid = 1'b1;
                    end
                end else begin
                    bus.spi_tx_ready = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic prep(input vec_t v);
        tx_q.delete();
        rsp_cnt = 0; err_cnt = 0; proto_err = 0; stall_cnt = 0;
        ptr = 0; pending = 8'($urandom); rsp_seen = 32'h0;
        rdata = v.rdata; rx_delay = v.rx_delay; ready_mode = v.ready_mode;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int n, exp_n, bad;
        prep(v);
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_op = v.op; bus.cmd_address = v.addr; bus.cmd_value = v.val;
        tick();
        if (v.poke) begin
            bus.cmd_op = 8'h01;
            bus.cmd_address = 24'($urandom);
            poke = 1'b1;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        n = 0;
        while (rsp_cnt + err_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 400), 32'd1);
        check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
        poke = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        exp_n = build_frame(v.op, v.addr, v.val);
        check({tag, "_tx_len"}, 32'(tx_q.size()), 32'(v.exp_len));
        bad = 0;
        for (int i = 0; i < exp_n && i < tx_q.size(); i++) begin
            if (tx_q[i] !== exp_f[i]) begin
                if (bad == 0) $display("FAIL %s_tx_byte[%0d]: got %0h expected %0h", tag, i, tx_q[i], exp_f[i]);
                bad++;
            end
        end
        check({tag, "_tx_bytes_bad"}, 32'(bad), 32'd0);
        check({tag, "_rsp_valid_cnt"}, 32'(rsp_cnt), v.exp_err ? 32'd0 : 32'd1);
        check({tag, "_rsp_error_cnt"}, 32'(err_cnt), v.exp_err ? 32'd1 : 32'd0);
        if (!v.exp_err) check({tag, "_rsp_at_pulse"}, rsp_seen, v.exp_rsp);
        check({tag, "_rsp_value_held"}, bus.rsp_value, v.exp_rsp);
        check({tag, "_protocol"}, 32'(proto_err), 32'd0);
        if (v.ready_mode == 2) check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd5);
        model_rsp = v.exp_rsp;
    endtask

    initial begin
        vec_t v;
        int n;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 8'h00; bus.cmd_address = 24'h0; bus.cmd_value = 32'h0;
        bus.spi_tx_ready = 1'b1; bus.spi_rx_valid = 1'b0; bus.spi_rx_byte = 8'h00;
        rx_cnt = 0; rx_delay = 2; ready_mode = 0; stall_cnt = 0; ptr = 0;
        rx_next = 8'h00; pending = 8'h00; rdata = 32'h0; rsp_seen = 32'h0; model_rsp = 32'h0;
        rsp_cnt = 0; err_cnt = 0; proto_err = 0;
        prev_stall = 1'b0; legit_rx = 1'b0; poke = 1'b0; inject_rx = 1'b0; prev_byte = 8'h00;

        tbl[0] = '{8'h01, 24'h000010, 32'hDEADBEEF, 32'h0,        2, 0, 1'b0, 8,      1'b0, 32'h0};
        tbl[1] = '{8'h02, 24'hABCDEF, 32'h55AA55AA, 32'h12345678, 2, 0, 1'b0, RD_LEN, 1'b0, 32'h12345678};
        tbl[2] = '{8'h07, 24'h123456, 32'h11111111, 32'h0,        2, 0, 1'b0, 0,      1'b1, 32'h12345678};
        tbl[3] = '{8'h01, 24'h00BEEF, 32'h01020304, 32'h0,        1, 2, 1'b1, 8,      1'b0, 32'h12345678};
        tbl[4] = '{8'h02, 24'h000001, 32'h0,        32'hCAFEF00D, 3, 1, 1'b0, RD_LEN, 1'b0, 32'hCAFEF00D};
        tbl[5] = '{8'h02, 24'h040404, 32'hFFFFFFFF, 32'h80000001, 1, 0, 1'b0, RD_LEN, 1'b0, 32'h80000001};

        repeat (3) tick();
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset_tx_valid", 32'(bus.spi_tx_valid), 32'd0);
        check("reset_tx_byte", 32'(bus.spi_tx_byte), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
        check("reset_rsp_value", bus.rsp_value, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset while byte 2 of a READ is being offered.
        v = '{8'h02, 24'hABCDEF, 32'h0, 32'h12345678, 2, 0, 1'b0, RD_LEN, 1'b0, 32'h0};
        prep(v);
        bus.cmd_valid = 1'b1; bus.cmd_op = v.op; bus.cmd_address = v.addr; bus.cmd_value = v.val;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.spi_tx_valid && tx_q.size() == 2) && n < 100) begin
            tick();
            n++;
        end
        check("mid_reset_reach", 32'(n < 100), 32'd1);
        ready_mode = 3;
        bus.spi_tx_ready = 1'b0;
        rst = 1'b1;
        rx_cnt = 0;
        tick();
        check("mid_reset_tx_valid", 32'(bus.spi_tx_valid), 32'd0);
        check("mid_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        prev_stall = 1'b0;
        ready_mode = 0;
        inject_rx = 1'b1;
        repeat (6) tick();
        check("mid_reset_no_rsp", 32'(rsp_cnt + err_cnt), 32'd0);
        check("mid_reset_no_tx", 32'(tx_q.size()), 32'd2);
        check("mid_reset_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_reset_rsp_value", bus.rsp_value, 32'd0);
        check("mid_reset_protocol", 32'(proto_err), 32'd0);
        model_rsp = 32'h0;
        run_cmd('{8'h01, 24'h00C0DE, 32'hA5A5F00F, 32'h0, 2, 0, 1'b0, 8, 1'b0, 32'h0}, "post_reset_write");

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            v.addr = 24'($urandom); v.val = $urandom; v.rdata = $urandom;
            v.rx_delay = $urandom_range(1, 4); v.ready_mode = 1; v.poke = 1'b0;
            if (sel == 0) begin
                do v.op = 8'($urandom); while (v.op == 8'h01 || v.op == 8'h02);
            end else if (sel < 5) begin
                v.op = 8'h01;
            end else begin
                v.op = 8'h02;
            end
            v.exp_err = (v.op != 8'h01 && v.op != 8'h02);
            v.exp_len = (v.op == 8'h01) ? 8 : (v.op == 8'h02) ? RD_LEN : 0;
            v.exp_rsp = (v.op == 8'h02) ? v.rdata : model_rsp;
            run_cmd(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
